// File: rtl/gc_pkg.sv
// Shared constants and types for the controller input conditioner.
package gc_pkg;

  // Button indices into btn_raw / btn_level / btn_press / btn_release
  localparam int BTN_A       = 0;
  localparam int BTN_B       = 1;
  localparam int BTN_X       = 2;
  localparam int BTN_Y       = 3;
  localparam int BTN_START   = 4;
  localparam int BTN_L       = 5;
  localparam int BTN_R       = 6;
  localparam int BTN_Z       = 7;
  localparam int BTN_D_UP    = 8;
  localparam int BTN_D_DOWN  = 9;
  localparam int BTN_D_RIGHT = 10;
  localparam int BTN_D_LEFT  = 11;
  localparam int NUM_BTN     = 12;

  // Direction indices into dir_level / dir_pulse
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_RIGHT = 2;
  localparam int DIR_LEFT  = 3;
  localparam int NUM_DIR   = 4;

  localparam int STICK_CENTER = 128;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/gc_debounce.sv
// Single-bit debouncer: the level follows raw only after raw has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles. rise/fall pulse in the
// first cycle the new level is visible.
module gc_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Disagreement counter, accepted level and edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        cnt   <= '0;
        level <= raw;
        rise  <= raw;
        fall  <= ~raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gc_input_conditioner.sv
// Controller input conditioner: debounced buttons, dead-banded stick
// directions merged with the D-pad, and per-direction navigation pulses.
// Define GC_AUTO_REPEAT_EN to build the auto-repeat FSM; without it a
// direction pulses only on its rising edge and no repeat counters exist.
//
// Repeat FSM (one per direction, GC_AUTO_REPEAT_EN only)
//   state      | meaning
//   RPT_IDLE   | direction inactive; a rise pulses and loads the delay
//   RPT_DELAY  | held, counting down to the first repeat
//   RPT_REPEAT | held, pulsing every REPEAT_PERIOD cycles
module gc_input_conditioner
  import gc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEADZONE        = 32,
  parameter int REPEAT_DELAY    = 40000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] btn_raw,
  input  logic [7:0]  joy_x,
  input  logic [7:0]  joy_y,
  output logic [11:0] btn_level,
  output logic [11:0] btn_press,
  output logic [11:0] btn_release,
  output logic [3:0]  dir_level,
  output logic [3:0]  dir_pulse
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("gc_input_conditioner: cycle-count parameters must be >= 1");
  end

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    gc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[b]),
      .level (btn_level[b]),
      .rise  (btn_press[b]),
      .fall  (btn_release[b])
    );
  end

  // A dead band reaching the rails pushes the thresholds out of the 8-bit
  // range, so the compares below can never fire.
  localparam bit         STICK_EN = (DEADZONE < STICK_CENTER);
  localparam logic [8:0] TH_HI    = STICK_EN ? 9'(STICK_CENTER + DEADZONE) : 9'h1FF;
  localparam logic [8:0] TH_LO    = STICK_EN ? 9'(STICK_CENTER - DEADZONE) : 9'h000;

  logic [7:0]         joy_x_q;
  logic [7:0]         joy_y_q;
  logic               joy_vld_q;
  logic [NUM_DIR-1:0] stick_dir;
  logic [NUM_DIR-1:0] merged_dir;

  // Stick sample register; valid flag keeps the zeroed reset sample from
  // reading as down+left
  always_ff @(posedge clk) begin
    if (reset) begin
      joy_x_q   <= '0;
      joy_y_q   <= '0;
      joy_vld_q <= 1'b0;
    end else begin
      joy_x_q   <= joy_x;
      joy_y_q   <= joy_y;
      joy_vld_q <= 1'b1;
    end
  end

  // Stick thresholds, D-pad merge and opposing-direction cancellation
  always_comb begin
    stick_dir = '0;
    if (joy_vld_q) begin
      stick_dir[DIR_UP]    = ({1'b0, joy_y_q} > TH_HI);
      stick_dir[DIR_DOWN]  = ({1'b0, joy_y_q} < TH_LO);
      stick_dir[DIR_RIGHT] = ({1'b0, joy_x_q} > TH_HI);
      stick_dir[DIR_LEFT]  = ({1'b0, joy_x_q} < TH_LO);
    end
    merged_dir = stick_dir | btn_level[BTN_D_LEFT:BTN_D_UP];
    dir_level  = merged_dir;
    if (merged_dir[DIR_UP] && merged_dir[DIR_DOWN]) begin
      dir_level[DIR_UP]   = 1'b0;
      dir_level[DIR_DOWN] = 1'b0;
    end
    if (merged_dir[DIR_RIGHT] && merged_dir[DIR_LEFT]) begin
      dir_level[DIR_RIGHT] = 1'b0;
      dir_level[DIR_LEFT]  = 1'b0;
    end
  end

`ifdef GC_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LD = RPT_W'(REPEAT_PERIOD - 1);

  rpt_state_t       state_q [NUM_DIR];
  rpt_state_t       state_d [NUM_DIR];
  logic [RPT_W-1:0] cnt_q   [NUM_DIR];
  logic [RPT_W-1:0] cnt_d   [NUM_DIR];

  // Repeat FSM state and down-counter registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DIR; i++) begin
      if (reset) begin
        state_q[i] <= RPT_IDLE;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next state and pulses; a release always wins over a due pulse
  always_comb begin
    dir_pulse = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!dir_level[i]) begin
        state_d[i] = RPT_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          RPT_IDLE: begin
            dir_pulse[i] = 1'b1;
            state_d[i]   = RPT_DELAY;
            cnt_d[i]     = DELAY_LD;
          end
          RPT_DELAY, RPT_REPEAT: begin
            if (cnt_q[i] == '0) begin
              dir_pulse[i] = 1'b1;
              state_d[i]   = RPT_REPEAT;
              cnt_d[i]     = PERIOD_LD;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
          default: begin
            state_d[i] = RPT_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end
`else
  logic [NUM_DIR-1:0] dir_prev_q;

  // Previous direction level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) dir_prev_q <= '0;
    else       dir_prev_q <= dir_level;
  end

  assign dir_pulse = dir_level & ~dir_prev_q;
`endif

endmodule

// File: tb/tb_gc_input_conditioner.sv
// Bench for gc_input_conditioner: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model.
module tb_gc_input_conditioner;

  localparam int DB = 4;
  localparam int DZ = 32;
  localparam int RD = 10;
  localparam int RP = 3;

`ifdef GC_AUTO_REPEAT_EN
  localparam bit AUTO_RPT = 1'b1;
`else
  localparam bit AUTO_RPT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] btn_raw;
  logic [7:0]  joy_x, joy_y;
  logic [11:0] btn_level, btn_press, btn_release;
  logic [3:0]  dir_level, dir_pulse;

  always #5 clk = ~clk;

  gc_input_conditioner #(
    .DEBOUNCE_CYCLES(DB), .DEADZONE(DZ), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .joy_x(joy_x), .joy_y(joy_y),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .dir_level(dir_level), .dir_pulse(dir_pulse)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a button level flips once the last DB samples all
  // disagree with it; a held direction pulses at age 0 and, with auto-repeat,
  // at ages RD, RD+RP, RD+2RP, ...
  bit          hist [12][DB];
  bit   [11:0] m_lvl;
  bit   [3:0]  m_prev;
  int          age [4];
  logic [11:0] e_lvl, e_press, e_rel;
  logic [3:0]  e_dl, e_dp;

  task automatic model_edge();
    bit       all_diff;
    bit [3:0] d;
    int       jx, jy;
    if (reset) begin
      for (int b = 0; b < 12; b++) for (int k = 0; k < DB; k++) hist[b][k] = 1'b0;
      m_lvl = '0; m_prev = '0;
      for (int i = 0; i < 4; i++) age[i] = 0;
      e_lvl = '0; e_press = '0; e_rel = '0; e_dl = '0; e_dp = '0;
      return;
    end
    e_press = '0; e_rel = '0;
    for (int b = 0; b < 12; b++) begin
      for (int k = DB - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = btn_raw[b];
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) if (hist[b][k] == m_lvl[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[b] = ~m_lvl[b];
        if (m_lvl[b]) e_press[b] = 1'b1;
        else          e_rel[b]   = 1'b1;
      end
    end
    e_lvl = m_lvl;
    jx = int'(joy_x); jy = int'(joy_y);
    d[0] = (DZ < 128 && jy > 128 + DZ) || m_lvl[8];
    d[1] = (DZ < 128 && jy < 128 - DZ) || m_lvl[9];
    d[2] = (DZ < 128 && jx > 128 + DZ) || m_lvl[10];
    d[3] = (DZ < 128 && jx < 128 - DZ) || m_lvl[11];
    if (d[0] && d[1]) begin d[0] = 1'b0; d[1] = 1'b0; end
    if (d[2] && d[3]) begin d[2] = 1'b0; d[3] = 1'b0; end
    e_dl = d;
    for (int i = 0; i < 4; i++) begin
      e_dp[i] = 1'b0;
      if (d[i]) begin
        age[i] = m_prev[i] ? age[i] + 1 : 0;
        e_dp[i] = (age[i] == 0) ||
                  (AUTO_RPT && age[i] >= RD && ((age[i] - RD) % RP) == 0);
      end
      m_prev[i] = d[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("btn_level",   32'(btn_level),   32'(e_lvl));
    check("btn_press",   32'(btn_press),   32'(e_press));
    check("btn_release", 32'(btn_release), 32'(e_rel));
    check("dir_level",   32'(dir_level),   32'(e_dl));
    check("dir_pulse",   32'(dir_pulse),   32'(e_dp));
  endtask

  int first, np, last;
  int jv [10] = '{0, 95, 96, 97, 128, 159, 160, 161, 200, 255};

  initial begin
    reset = 1'b1; btn_raw = '0; joy_x = 8'd128; joy_y = 8'd128;
    repeat (3) step();
    reset = 1'b0;
    step();

    // A held: press on the 4th edge, release 4 edges after letting go
    btn_raw[0] = 1'b1; first = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (first < 0 && btn_press[0]) first = k;
    end
    check("a_press_edge", 32'(first), 32'd4);
    btn_raw[0] = 1'b0; first = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (first < 0 && btn_release[0]) first = k;
    end
    check("a_release_edge", 32'(first), 32'd4);

    // B glitching with 2-cycle halves never settles
    np = 0;
    for (int k = 0; k < 8; k++) begin
      btn_raw[1] = ((k / 2) % 2 == 0);
      step();
      if (btn_level[1] || btn_press[1] || btn_release[1]) np++;
    end
    btn_raw[1] = 1'b0;
    repeat (6) begin step(); if (btn_level[1] || btn_press[1] || btn_release[1]) np++; end
    check("b_glitch_activity", 32'(np), 32'd0);

    // Stick thresholds
    joy_x = 8'd160; step(); check("x160_right", 32'(dir_level[2]), 32'd0);
    joy_x = 8'd161; step(); check("x161_right", 32'(dir_level[2]), 32'd1);
    joy_x = 8'd128; step();
    joy_y = 8'd95;  step(); check("y95_down", 32'(dir_level[1]), 32'd1);
    joy_y = 8'd96;  step(); check("y96_down", 32'(dir_level[1]), 32'd0);
    joy_y = 8'd128; repeat (2) step();

    // Up held, returned to centre at t0+12
    joy_y = 8'd200; step();
    check("up_t0_pulse", 32'(dir_pulse[0]), 32'd1);
    np = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (dir_pulse[0]) np++;
      if (k == 12) joy_y = 8'd128;
    end
    check("up_short_pulses", 32'(np), AUTO_RPT ? 32'd1 : 32'd0);

    // Up held for 20 cycles: full repeat train
    joy_y = 8'd200; np = 0; last = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (dir_pulse[0]) begin np++; last = k; end
    end
    check("up_long_pulses", 32'(np), AUTO_RPT ? 32'd5 : 32'd1);
    check("up_long_last", 32'(last), AUTO_RPT ? 32'd19 : 32'd0);
    joy_y = 8'd128; repeat (3) step();

    // D_LEFT plus stick hard right cancel each other
    btn_raw[11] = 1'b1; repeat (6) step();
    joy_x = 8'd255; np = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (dir_level[3:2] != 2'b00 || dir_pulse[3:2] != 2'b00) np++;
    end
    check("lr_cancel", 32'(np), 32'd0);
    joy_x = 8'd128; step();
    btn_raw[11] = 1'b0; repeat (6) step();

    // Reset mid-repeat and mid-debounce
    joy_y = 8'd200; step();
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 9) btn_raw[0] = 1'b1;
    end
    reset = 1'b1; step();
    check("rst_btn_zero", 32'({btn_level, btn_press, btn_release}), 32'd0);
    check("rst_dir_zero", 32'({dir_level, dir_pulse}), 32'd0);
    reset = 1'b0; step();
    check("rst_fresh_pulse", 32'(dir_pulse[0]), 32'd1);
    first = btn_press[0] ? 1 : -1;
    for (int k = 2; k <= 8; k++) begin
      step();
      if (first < 0 && btn_press[0]) first = k;
    end
    check("rst_press_edge", 32'(first), 32'd4);
    btn_raw = '0; joy_y = 8'd128; repeat (6) step();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0)
        btn_raw = btn_raw ^ 12'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) joy_x = 8'(jv[$urandom_range(0, 9)]);
      if ($urandom_range(0, 15) == 0) joy_y = 8'(jv[$urandom_range(0, 9)]);
      if ($urandom_range(0, 30) == 0) joy_x = 8'($urandom);
      reset = ($urandom_range(0, 200) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
